// File: rtl/tl_sensor_cond.sv
// tl_sensor_cond: conditions two asynchronous vehicle detectors into per-street
// queue counts and traffic-present flags for a traffic-light controller.
// Each lane: 2-flop synchronizer -> debounce filter -> arrival on filtered rise;
// a green-light departure timer drains the queue one car per DEP_CYC cycles.
module tl_sensor_cond #(
   parameter int DB_CYC  = 3,
   parameter int DEP_CYC = 4,
   parameter int QMAX    = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sa_raw,
   input  logic       sb_raw,
   input  logic [1:0] La,
   input  logic [1:0] Lb,
   output logic       Ta,
   output logic       Tb,
   output logic [3:0] qa_cnt,
   output logic [3:0] qb_cnt,
   output logic       ovf
);

   typedef enum logic [1:0] {
      LIGHT_GREEN  = 2'b00,
      LIGHT_YELLOW = 2'b01,
      LIGHT_RED    = 2'b10
   } light_e;

   localparam logic [3:0] DB_LIM  = 4'(DB_CYC);
   localparam logic [3:0] DEP_LIM = 4'(DEP_CYC);
   localparam logic [3:0] Q_LIM   = 4'(QMAX);

   // Lane 0 is street A, lane 1 is street B.
   logic [1:0]      raw;
   logic [1:0][1:0] light;
   logic [1:0]      sync1, sync2, filt;
   logic [1:0][3:0] db_cnt, dep_tmr, q, q_nxt;
   logic [1:0]      db_hit, arr, tmr_run, dep, drop, t_r;
   logic            ovf_r;

   assign raw   = {sb_raw, sa_raw};
   assign light = {Lb, La};

   // Per-lane next-state decisions: filter acceptance, arrival, departure, queue.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      db_hit  = '0;
      arr     = '0;
      tmr_run = '0;
      dep     = '0;
      drop    = '0;
      q_nxt   = q;
      for (int i = 0; i < 2; i++) begin
         db_hit[i]  = (sync2[i] != filt[i]) && ((db_cnt[i] + 4'd1) == DB_LIM);
         arr[i]     = db_hit[i] & sync2[i];
         tmr_run[i] = (light[i] == LIGHT_GREEN) && (q[i] != 4'd0);
         dep[i]     = tmr_run[i] && ((dep_tmr[i] + 4'd1) == DEP_LIM);
         if (arr[i] && !dep[i]) begin
            if (q[i] == Q_LIM) drop[i] = 1'b1;
            else               q_nxt[i] = q[i] + 4'd1;
         end else if (dep[i] && !arr[i]) begin
            q_nxt[i] = q[i] - 4'd1;
         end
      end
   end

   // Two-flop synchronizer on both raw detectors.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         // NOTE: non-blocking assignments keep this a true two-stage shift; blocking would collapse it to one flop.
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Debounce: the filtered level follows the synchronized level only after DB_CYC agreeing cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt   <= '0;
         db_cnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               db_cnt[i] <= 4'd0;
            end else if (db_hit[i]) begin
               filt[i]   <= sync2[i];
               db_cnt[i] <= 4'd0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 4'd1;
            end
         end
      end
   end

   // Departure timers: run only on green with cars waiting, clear on each departure.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dep_tmr <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!tmr_run[i] || dep[i]) dep_tmr[i] <= 4'd0;
            else                       dep_tmr[i] <= dep_tmr[i] + 4'd1;
         end
      end
   end

   // Queue counters, traffic-present flags from the next-state count, sticky overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q     <= '0;
         t_r   <= '0;
         ovf_r <= 1'b0;
      end else begin
         q <= q_nxt;
         for (int i = 0; i < 2; i++) begin
            t_r[i] <= (q_nxt[i] != 4'd0);
         end
         ovf_r <= ovf_r | (|drop);
      end
   end

   assign qa_cnt = q[0];
   assign qb_cnt = q[1];
   assign Ta     = t_r[0];
   assign Tb     = t_r[1];
   assign ovf    = ovf_r;

endmodule

// File: tb/tb_tl_sensor_cond.sv
// tb_tl_sensor_cond: directed scenarios with hand-computed expectations, plus a
// behavioural queue model compared against the DUT on every falling clock edge.
module tb_tl_sensor_cond;

   localparam int DB  = 3;
   localparam int DEP = 4;
   localparam int QM  = 15;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic       sa_raw  = 1'b0;
   logic       sb_raw  = 1'b0;
   logic [1:0] La      = 2'b10;
   logic [1:0] Lb      = 2'b10;
   logic       Ta, Tb, ovf;
   logic [3:0] qa_cnt, qb_cnt;

   int tests = 0;
   int fails = 0;
   bit run_cmp = 1'b0;

   always #5 clk = ~clk;

   tl_sensor_cond #(.DB_CYC(DB), .DEP_CYC(DEP), .QMAX(QM)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sa_raw  (sa_raw),
      .sb_raw  (sb_raw),
      .La      (La),
      .Lb      (Lb),
      .Ta      (Ta),
      .Tb      (Tb),
      .qa_cnt  (qa_cnt),
      .qb_cnt  (qb_cnt),
      .ovf     (ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a filtered level flips when the last DB synchronized
   // samples all disagree with it; a car leaves after DEP straight green cycles.
   bit m_pipe [2][2];
   bit m_win  [2][16];
   bit m_filt [2];
   int m_q    [2];
   int m_grun [2];
   bit m_ovf;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            m_pipe[i][0] = 0; m_pipe[i][1] = 0;
            for (int j = 0; j < 16; j++) m_win[i][j] = 0;
            m_filt[i] = 0; m_q[i] = 0; m_grun[i] = 0;
         end
         m_ovf = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit rawv, seen, all_diff, arrive, depart;
            logic [1:0] lt;
            rawv = (i == 0) ? sa_raw : sb_raw;
            lt   = (i == 0) ? La : Lb;
            seen = m_pipe[i][1];
            for (int j = 15; j > 0; j--) m_win[i][j] = m_win[i][j-1];
            m_win[i][0] = seen;
            all_diff = 1;
            for (int j = 0; j < DB; j++) if (m_win[i][j] == m_filt[i]) all_diff = 0;
            arrive = all_diff && !m_filt[i];
            if (all_diff) m_filt[i] = !m_filt[i];
            depart = 0;
            if (lt == 2'b00 && m_q[i] > 0) begin
               m_grun[i]++;
               if (m_grun[i] == DEP) begin
                  depart = 1;
                  m_grun[i] = 0;
               end
            end else begin
               m_grun[i] = 0;
            end
            if (arrive && !depart) begin
               if (m_q[i] == QM) m_ovf = 1;
               else              m_q[i]++;
            end else if (depart && !arrive) begin
               m_q[i]--;
            end
            m_pipe[i][1] = m_pipe[i][0];
            m_pipe[i][0] = rawv;
         end
      end
   end

   // Compare DUT against the model away from the active edge.
   always @(negedge clk) begin
      if (reset_n && run_cmp) begin
         check("cmp_qa",  qa_cnt, m_q[0]);
         check("cmp_qb",  qb_cnt, m_q[1]);
         check("cmp_ta",  Ta,     (m_q[0] != 0));
         check("cmp_tb",  Tb,     (m_q[1] != 0));
         check("cmp_ovf", ovf,    m_ovf);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_a();
      sa_raw = 1'b1; tick(6);
      sa_raw = 1'b0; tick(6);
   endtask

   task automatic pulse_b();
      sb_raw = 1'b1; tick(6);
      sb_raw = 1'b0; tick(6);
   endtask

   task automatic pulse_ab();
      sa_raw = 1'b1; sb_raw = 1'b1; tick(6);
      sa_raw = 1'b0; sb_raw = 1'b0; tick(6);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_qa"},  qa_cnt, 0);
      check({tag, "_qb"},  qb_cnt, 0);
      check({tag, "_ta"},  Ta,     0);
      check({tag, "_tb"},  Tb,     0);
      check({tag, "_ovf"}, ovf,    0);
   endtask

   initial begin
      // Reset state
      #12;
      check_all_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;
      run_cmp = 1'b1;
      tick(2);

      // Clean arrival on A: queue updates on the 5th edge after the rise
      sa_raw = 1'b1;
      tick(4);
      check("arr_e4_qa", qa_cnt, 0);
      tick(1);
      check("arr_e5_qa", qa_cnt, 1);
      check("arr_e5_ta", Ta, 1);
      check("arr_e5_tb", Tb, 0);
      tick(5);
      sa_raw = 1'b0;
      tick(6);
      check("arr_fall_qa", qa_cnt, 1);

      // Glitch on B shorter than the debounce window
      sb_raw = 1'b1; tick(2);
      sb_raw = 1'b0; tick(8);
      check("glitch_qb", qb_cnt, 0);
      check("glitch_tb", Tb, 0);

      // Discharge A from 3 on green
      pulse_a(); pulse_a();
      check("dis_fill_qa", qa_cnt, 3);
      La = 2'b00;
      tick(3); check("dis_c3_qa",  qa_cnt, 3);
      tick(1); check("dis_c4_qa",  qa_cnt, 2);
      tick(4); check("dis_c8_qa",  qa_cnt, 1);
      tick(4); check("dis_c12_qa", qa_cnt, 0);
      check("dis_c12_ta", Ta, 0);
      La = 2'b10;

      // Yellow mid-count freezes the queue and restarts the timer
      pulse_a(); pulse_a();
      La = 2'b00; tick(2);
      La = 2'b01; tick(6);
      check("frz_yel_qa", qa_cnt, 2);
      La = 2'b00;
      tick(3); check("frz_g3_qa", qa_cnt, 2);
      tick(1); check("frz_g4_qa", qa_cnt, 1);
      tick(4); check("frz_g8_qa", qa_cnt, 0);
      La = 2'b10;

      // Saturation on A and sticky overflow
      for (int k = 0; k < 15; k++) pulse_a();
      check("sat15_qa",  qa_cnt, 15);
      check("sat15_ovf", ovf, 0);
      pulse_a();
      check("sat16_qa",  qa_cnt, 15);
      check("sat16_ovf", ovf, 1);
      La = 2'b00; tick(60);
      check("sat_drain_qa",  qa_cnt, 0);
      check("sat_drain_ovf", ovf, 1);
      La = 2'b10;

      // Synchronous-style reset to clear overflow
      reset_n = 1'b0; tick(2);
      check_all_zero("rst2");
      reset_n = 1'b1; tick(2);

      // Arrival and departure on the same edge at full B queue
      for (int k = 0; k < 15; k++) pulse_b();
      check("sim_fill_qb",  qb_cnt, 15);
      check("sim_fill_ovf", ovf, 0);
      sb_raw = 1'b1; tick(1);
      Lb = 2'b00;    tick(3);
      check("sim_pre_qb", qb_cnt, 15);
      tick(1);
      check("sim_edge_qb",  qb_cnt, 15);
      check("sim_edge_ovf", ovf, 0);
      tick(4);
      check("sim_next_qb", qb_cnt, 14);
      sb_raw = 1'b0;
      tick(56);
      check("sim_drain_qb", qb_cnt, 0);
      Lb = 2'b10;

      // Simultaneous arrivals on both lanes, then build qa=5 qb=2
      pulse_ab();
      check("both_qa", qa_cnt, 1);
      check("both_qb", qb_cnt, 1);
      pulse_ab(); pulse_a(); pulse_a(); pulse_a();
      check("mid_qa", qa_cnt, 5);
      check("mid_qb", qb_cnt, 2);

      // Off-edge reset pulse with detector held high
      sa_raw = 1'b1;
      #1 reset_n = 1'b0;
      #1 check_all_zero("async");
      #2 reset_n = 1'b1;
      @(negedge clk);
      tick(3);
      check("post_e4_qa", qa_cnt, 0);
      tick(1);
      check("post_e5_qa", qa_cnt, 1);
      check("post_e5_ta", Ta, 1);
      sa_raw = 1'b0;
      tick(8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tl_sensor_cond.md
TL_SENSOR_COND -- requirements
Module: tl_sensor_cond

Interface
REQ-001 The parameter list SHALL be: DB_CYC, default 3, consecutive synchronized cycles a detector level must hold before it is accepted (range 1..15).
REQ-002 The parameter list SHALL include: DEP_CYC, default 4, green cycles per car discharged from a queue (range 1..15).
REQ-003 The parameter list SHALL include: QMAX, default 15, queue saturation value; queue counters SHALL be 4 bits.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low. Ports are listed in REQ-005 to REQ-014.
REQ-005 clk  input  1  system clock, rising-edge active.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 sa_raw  input  1  street A vehicle detector, asynchronous, may bounce.
REQ-008 sb_raw  input  1  street B vehicle detector, asynchronous, may bounce.
REQ-009 La  input  2  street A light state from the controller: 2'b00 green, 2'b01 yellow, 2'b10 red.
REQ-010 Lb  input  2  street B light state, same encoding as La.
REQ-011 Ta  output  1  street A traffic present (queue A nonzero), registered; feeds the controller.
REQ-012 Tb  output  1  street B traffic present (queue B nonzero), registered.
REQ-013 qa_cnt, qb_cnt  output  4 each  current queue occupancy per street.
REQ-014 ovf  output  1  sticky flag: an arrival was dropped at saturation.

Function
REQ-015 Each raw detector SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 Each lane SHALL keep a filtered level and a debounce counter.
- Counter clears on any cycle where the synchronized level equals the filtered level.
- Otherwise the counter increments.
- The filtered level takes the synchronized value on the edge the counter would reach DB_CYC.
REQ-017 A pulse shorter than DB_CYC synchronized cycles SHALL NOT change the filtered level.
REQ-018 A 0->1 transition of the filtered level SHALL be one arrival. Arrival latency from a clean raw rise: the queue and T output update on clock edge 2+DB_CYC (edge 5 at default).
REQ-019 Each lane SHALL have a departure timer.
- Counts only while its light is green (00) and its queue is nonzero.
- Clears when the light is not green or the queue is 0.
- On the edge it would reach DEP_CYC, the timer clears and one departure occurs.
REQ-020 Yellow and red SHALL produce no departures.
REQ-021 Queue update per edge:
- arrival only: +1.
- departure only: -1.
- arrival and departure on the same edge: unchanged, including at QMAX.
REQ-022 At QMAX, an arrival without a departure SHALL be dropped, the count SHALL hold at QMAX, and ovf SHALL set.
REQ-023 At 0 no departure SHALL occur; the queue never wraps in either direction.
REQ-024 Ta and Tb SHALL be registered from the next-state queue value, so Ta is 1 in exactly the cycles qa_cnt is nonzero; same for Tb and qb_cnt.
REQ-025 Lanes A and B SHALL be fully independent; simultaneous events on both lanes SHALL each be handled.
REQ-026 ovf SHALL remain 1 until reset.

Reset
REQ-027 On reset_n low, asynchronously:
- Ta, Tb, ovf = 0; qa_cnt, qb_cnt = 0.
- Synchronizer flops, filtered levels, debounce counters and departure timers = 0.
REQ-028 Reset asserted mid-operation SHALL discard all queued cars.
REQ-029 After reset_n rises, a detector already held high SHALL count as one arrival after the normal filter latency.

Verification
REQ-030 Clean arrival: reset release, La=10, sa_raw 0->1 held 10 cycles -> qa_cnt=1 and Ta=1 at edge 5 after the rise; Tb=0 throughout.
REQ-031 Glitch reject: sb_raw high for 2 cycles, then low -> qb_cnt stays 0 and Tb stays 0.
REQ-032 Discharge: qa_cnt=3, La set to 00 -> qa_cnt is 2, 1, 0 at 4, 8 and 12 cycles; Ta falls with the last decrement; a switch to La=01 mid-count freezes qa_cnt and clears the timer.
REQ-033 Saturation: 16 debounced arrivals on A while La=10 -> qa_cnt=15 and ovf=1; ovf still 1 after La=00 drains to 0.
REQ-034 Simultaneous event: qb_cnt=15, Lb=00, arrival on the same edge as a departure -> qb_cnt stays 15 and ovf stays 0.
REQ-035 Reset mid-run: qa_cnt=5, qb_cnt=2, reset_n pulsed low for 3 ns off-edge -> all outputs 0 immediately; sa_raw held high -> qa_cnt=1 five edges after release.
